// File: rtl/mult_div_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_e;

endpackage : mult_div_pkg

// File: rtl/md_step.sv
// One iteration of shift-add multiply or restoring divide on magnitudes.
// The divide quotient bit is returned separately and left as 0 in acc_o.
module md_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               op_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_bit_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  // NOTE: every output and temporary is assigned on every path through this
  // block, otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    mul_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    div_shift = acc_i[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, opnd_i});
    // Only used when div_ge, where the true difference fits in WIDTH bits.
    div_diff  = div_shift[WIDTH-1:0] - opnd_i;

    if (op_i == OP_DIV) begin
      acc_o   = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_i[WIDTH-2:0], 1'b0};
      q_bit_o = div_ge;
    end else begin
      acc_o   = {mul_sum, acc_i[WIDTH-1:1]};
      q_bit_o = 1'b0;
    end
  end

endmodule : md_step

// File: rtl/mult_div_sequencer.sv
// Multi-cycle HI/LO multiply/divide sequencer: magnitude iteration in RUN,
// sign correction and HI/LO write in FIX, one-cycle done pulse in DONE.
module mult_div_sequencer
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_q, op_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  md_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .op_i    (op_q),
    .acc_o   (step_acc),
    .q_bit_o (step_q_bit)
  );

  // Negating 0x80000000 yields 0x80000000, which reads correctly as 2^31.
  assign a_neg = !is_unsigned && a[WIDTH-1];
  assign b_neg = !is_unsigned && b[WIDTH-1];
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;

  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quot_fix = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    op_d       = op_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d    = {{WIDTH{1'b0}}, abs_a};
          opnd_d   = abs_b;
          op_d     = op;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          cnt_d    = CNT_W'(WIDTH - 1);
          if (op == OP_DIV && b == '0) begin
            div_zero_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q_bit};
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIX: begin
        if (op_q == OP_MULT) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        div_zero_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value, independent of statement order or other blocks.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // NOTE: the iteration datapath is left out of reset; it is fully reloaded
  // on every accepted start and is never observed before that.
  always_ff @(posedge clock) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    op_q     <= op_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
  end

  assign busy     = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done     = (state_q == ST_DONE);
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule : mult_div_sequencer

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: a 64-bit arithmetic model queues
// expected HI/LO results, a monitor compares them whenever done is seen.
module tb_mult_div_sequencer;

  localparam logic MULT = 1'b0;
  localparam logic DIV  = 1'b1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic        is_unsigned;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int   checks     = 0;
  int   failures   = 0;
  int   done_count = 0;
  exp_t sb_q[$];

  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .is_unsigned (is_unsigned),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural values.
  task automatic push_expected(input logic o, input logic u, input logic [31:0] x,
                               input logic [31:0] y);
    exp_t        e;
    logic [63:0] prod;
    longint      sa, sb, q, r;
    e.dz = 1'b0;
    if (o == MULT) begin
      if (u) prod = {32'h0, x} * {32'h0, y};
      else   prod = 64'(longint'($signed(x)) * longint'($signed(y)));
      model_hi = prod[63:32];
      model_lo = prod[31:0];
    end else if (y == 32'h0) begin
      e.dz = 1'b1;
    end else if (u) begin
      model_lo = x / y;
      model_hi = x % y;
    end else begin
      sa = longint'($signed(x));
      sb = longint'($signed(y));
      q  = sa / sb;
      r  = sa % sb;
      model_lo = q[31:0];
      model_hi = r[31:0];
    end
    e.hi = model_hi;
    e.lo = model_lo;
    sb_q.push_back(e);
  endtask

  // Called just after a falling edge; returns one falling edge later.
  task automatic start_pulse(input logic o, input logic u, input logic [31:0] x,
                             input logic [31:0] y);
    start       = 1'b1;
    op          = o;
    is_unsigned = u;
    a           = x;
    b           = y;
    @(negedge clock);
    start       = 1'b0;
    op          = 1'($urandom);
    is_unsigned = 1'($urandom);
    a           = $urandom;
    b           = $urandom;
  endtask

  task automatic run_op(input logic o, input logic u, input logic [31:0] x,
                        input logic [31:0] y);
    int lat;
    int busy_cnt;
    bit dz;
    dz = (o == DIV) && (y == 32'h0);
    push_expected(o, u, x, y);
    start_pulse(o, u, x, y);
    lat      = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clock);
      lat++;
    end
    check("latency", 32'(lat), dz ? 32'd1 : 32'd34);
    check("busy_cycles", 32'(busy_cnt), dz ? 32'd0 : 32'd33);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("after_done_idle", {29'h0, busy, done, div_zero}, 32'h0);
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && done === 1'b1) begin
      exp_t e;
      done_count++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 hi=0x%08h lo=0x%08h", hi, lo);
      end else begin
        e = sb_q.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("div_zero", {31'h0, div_zero}, {31'h0, e.dz});
      end
    end
  end

  initial begin
    int          dc;
    logic        ro, ru;
    logic [31:0] rx, ry;

    reset = 1'b0;
    start = 1'b0;
    op = 1'b0;
    is_unsigned = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs", {27'h0, busy, done, div_zero, 2'b00}, 32'h0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    run_op(MULT, 1'b0, 32'd7, 32'hFFFF_FFFD);
    run_op(MULT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(DIV,  1'b0, 32'hFFFF_FFF9, 32'd2);
    run_op(DIV,  1'b1, 32'd100, 32'd7);
    run_op(MULT, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op(DIV,  1'b0, 32'd55, 32'h0);
    run_op(DIV,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(DIV,  1'b0, 32'h8000_0000, 32'd1);
    run_op(MULT, 1'b0, 32'h8000_0000, 32'h8000_0000);

    // Reset sampled low on edge 10 of a running MULT discards it.
    dc = done_count;
    start_pulse(MULT, 1'b0, 32'd1234, 32'd5678);
    repeat (8) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midrun_reset_ctrl", {29'h0, busy, done, div_zero}, 32'h0);
    check("midrun_reset_hi", hi, 32'h0);
    check("midrun_reset_lo", lo, 32'h0);
    reset = 1'b1;
    model_hi = '0;
    model_lo = '0;
    repeat (40) @(negedge clock);
    check("midrun_reset_no_done", 32'(done_count - dc), 32'd0);

    // A second start on edge 5 of a running op must be ignored.
    dc = done_count;
    push_expected(DIV, 1'b0, 32'hFFFF_FF00, 32'd9);
    start_pulse(DIV, 1'b0, 32'hFFFF_FF00, 32'd9);
    repeat (3) @(negedge clock);
    start_pulse(MULT, 1'b1, 32'hDEAD_BEEF, 32'h0000_0003);
    repeat (80) @(negedge clock);
    check("ignored_start_one_done", 32'(done_count - dc), 32'd1);

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom);
      ru = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       rx = 32'h8000_0000;
        1:       rx = $urandom_range(0, 20);
        default: rx = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       ry = 32'h0;
        1:       ry = 32'hFFFF_FFFF;
        2:       ry = $urandom_range(1, 20);
        default: ry = $urandom;
      endcase
      run_op(ro, ru, rx, ry);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mult_div_sequencer

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
Multi-cycle sequencer for the HI/LO multiply/divide resource of the multicycle CPU. The main control FSM issues a one-cycle start with operands taken from registers A/B. The block runs a 32-iteration shift-add multiply or restoring divide, applies the sign correction, and drives HI/LO with a done pulse. The control FSM holds in a wait state while busy is high.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
op  input  1  0 = MULT, 1 = DIV
is_unsigned  input  1  1 = MULTU/DIVU, 0 = signed
a  input  WIDTH  multiplicand or dividend (register A)
b  input  WIDTH  multiplier or divisor (register B)
busy  output  1  high in RUN and FIX
done  output  1  one-cycle pulse in DONE
div_zero  output  1  high with done when a DIV had b==0
hi  output  WIDTH  MULT: product[63:32]; DIV: remainder
lo  output  WIDTH  MULT: product[31:0]; DIV: quotient

Behaviour:
- Reset: any edge with reset==0 forces state IDLE, counter 0, and hi = lo = 0, busy = done = div_zero = 0. This applies in every state, including mid-RUN; a partial result is discarded.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start==1 at edge E0:
  - Capture |a| and |b|; signed mode negates negative operands; unsigned mode uses raw values.
  - Record result signs. MULT: product sign = sign(a) xor sign(b). DIV: quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - Load counter = WIDTH-1. Go to RUN.
- DIV with b==0 at E0: go directly to DONE, set div_zero=1, leave hi/lo unchanged. done is therefore high in the cycle after E0.
- RUN: one iteration per edge, E1..E32.
  - MULT: 2*WIDTH accumulator, add-and-shift right.
  - DIV: restoring; shift the remainder:quotient pair left, trial-subtract the divisor, keep the result if non-negative and set the quotient bit.
  - Counter==0 at an iteration edge: go to FIX.
- FIX (edge E33):
  - Negate the product or quotient per its recorded sign; negate the remainder per the dividend sign.
  - Write hi/lo. Go to DONE.
- DONE: done=1 for exactly one cycle (between E33 and E34); next edge goes to IDLE. div_zero clears on leaving DONE.
- Latency: start to done = 34 edges for normal operations; 1 edge for divide-by-zero.
- busy: 1 in RUN and FIX; 0 in IDLE and DONE.
- start outside IDLE is ignored, including in DONE; no queuing.
- hi/lo hold their last value except at the FIX write and at reset.
- Arithmetic: two's complement, no saturation.
  - Signed DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
  - |0x80000000| is handled as an unsigned 2^31 internally.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
- a/b are sampled only at E0; changes afterwards have no effect.

Decomposition:
- Package mult_div_pkg:
  - state enum (IDLE, RUN, FIX, DONE)
  - OP_MULT = 1'b0, OP_DIV = 1'b1
  - default WIDTH
- One combinational sub-module, md_step: a single iteration. Inputs: accumulator, operand, op. Outputs: next accumulator and quotient bit. The sequencer instantiates it once.

Test Plan:
- MULT signed, a=7, b=0xFFFFFFFD (-3) -> done 34 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV signed, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also DIVU, a=100, b=7 -> lo=14, hi=2.
- DIV, b=0, hi/lo preloaded from the prior MULT -> done and div_zero high one cycle after start; hi/lo unchanged; busy never high.
- DIV signed, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_zero=0.
- Reset low at edge 10 of a MULT -> IDLE next cycle, hi=lo=0, busy=0, no done. A second start pulsed at edge 5 of a running op is ignored, confirmed by exactly one done.
